// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// access-size codes and the misalignment rule.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Unsupported size codes fall into the word case, so they share its rule.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      LSU_B, LSU_BU: is_misaligned = 1'b0;
      LSU_H, LSU_HU: is_misaligned = addr_lo[0];
      default:       is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store byte enables and replicated write data, and
// load-data extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    lane_byte = rdata[{addr_lo, 3'b000} +: 8];
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      LSU_B, LSU_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'd0, lane_byte}
                              : {{24{lane_byte[7]}}, lane_byte};
      end
      LSU_H, LSU_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = funct3[2] ? {16'd0, lane_half}
                              : {{16{lane_half[15]}}, lane_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/gnt/rvalid data-memory handshake and one writeback
// beat per op. Optional misalignment trap enabled by LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        dstreg_num,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_dstreg,
  output logic [DATA_W-1:0] wb_data,
  output logic              misaligned
);

  lsu_state_e  state;
  logic [2:0]  op_funct3;
  logic [1:0]  op_addr_lo;

  logic [2:0]  align_funct3;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_load_data;

  assign in_ready = (state == ST_IDLE);

  // One aligner serves both directions: store steering is only needed at
  // accept (IDLE), load extraction only while waiting for rvalid.
  assign align_funct3  = (state == ST_IDLE) ? funct3 : op_funct3;
  assign align_addr_lo = (state == ST_IDLE) ? alu_result[1:0] : op_addr_lo;

  lsu_align u_align (
    .funct3     (align_funct3),
    .addr_lo    (align_addr_lo),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (align_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_funct3  <= 3'd0;
      op_addr_lo <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= 4'd0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_dstreg  <= 5'd0;
      wb_data    <= '0;
      misaligned <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge state and these pulse defaults are overridden cleanly.
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      misaligned <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_funct3  <= funct3;
            op_addr_lo <= alu_result[1:0];
            wb_dstreg  <= dstreg_num;
            if (!is_load && !is_store) begin
              state    <= ST_RESP;
              wb_valid <= 1'b1;
              wb_we    <= 1'b1;
              wb_data  <= DATA_W'(alu_result);
            end
`ifdef LSU_MISALIGN_TRAP_EN
            else if (is_misaligned(funct3, alu_result[1:0])) begin
              state      <= ST_RESP;
              wb_valid   <= 1'b1;
              misaligned <= 1'b1;
            end
`endif
            else begin
              // Load wins when both flags are set.
              state     <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= !is_load;
              mem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
              mem_be    <= is_load ? 4'b1111 : align_be;
              mem_wdata <= align_wdata;
            end
          end
        end

        ST_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'd0;
            if (mem_we) begin
              state    <= ST_RESP;
              wb_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (mem_rvalid) begin
            state    <= ST_RESP;
            wb_valid <= 1'b1;
            wb_we    <= 1'b1;
            wb_data  <= align_load_data;
          end
        end

        ST_RESP: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// ops checked against an arithmetic reference model of lane/extension rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dstreg_num;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_dstreg;
  logic [31:0] wb_data;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .alu_result (alu_result),
    .store_data (store_data),
    .dstreg_num (dstreg_num),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_dstreg  (wb_dstreg),
    .wb_data    (wb_data),
    .misaligned (misaligned)
  );

  // ---------------- reference model ----------------
  function automatic int model_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input int lo);
    int sz = model_size(f3);
    if (sz == 1) return 4'(1 << lo);
    if (sz == 2) return 4'(3 << ((lo / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz = model_size(f3);
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int lo,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int sz = model_size(f3);
    logic is_unsigned = (f3 >= 3'd4);
    if (sz == 1) begin
      v = (rd >> (8 * lo)) & 32'hFF;
      if (!is_unsigned && v >= 128) v = v - 32'd256;
      return v;
    end
    if (sz == 2) begin
      v = (rd >> (16 * (lo / 2))) & 32'hFFFF;
      if (!is_unsigned && v >= 32768) v = v - 32'd65536;
      return v;
    end
    return rd;
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input int lo);
    int sz = model_size(f3);
    if (sz == 2) return (lo % 2) != 0;
    if (sz == 4) return lo != 0;
    return 1'b0;
  endfunction

  // ---------------- generic op driver / checker ----------------
  task automatic do_op(input string name, input logic ld_i, input logic st_i,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] dst,
                       input logic [31:0] rd, input int gnt_dly, input int rv_dly);
    logic ld, st, trap, exp_we;
    logic [31:0] exp_data;
    int lo;
    lo   = int'(addr[1:0]);
    ld   = ld_i;
    st   = !ld_i && st_i;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (ld || st) && model_misaligned(f3, lo);
`endif
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready_before got=%b exp=1", name, in_ready);
    end
    in_valid   = 1'b1;
    is_load    = ld_i;
    is_store   = st_i;
    funct3     = f3;
    alu_result = addr;
    store_data = sd;
    dstreg_num = dst;
    @(negedge clk);
    // Scramble inputs after accept: the DUT must have registered them.
    in_valid   = 1'b0;
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    alu_result = $urandom;
    store_data = $urandom;
    dstreg_num = 5'($urandom);

    if ((ld || st) && !trap) begin
      for (int i = 0; i <= gnt_dly; i++) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== (addr & 32'hFFFF_FFFC)) begin
          failures++;
          $display("FAIL %s req_cyc%0d req/we/addr got=%b/%b/%h exp=1/%b/%h",
                   name, i, mem_req, mem_we, mem_addr, st, addr & 32'hFFFF_FFFC);
        end
        checks++;
        if (mem_be !== (ld ? 4'hF : model_be(f3, lo))) begin
          failures++;
          $display("FAIL %s mem_be got=%b exp=%b", name, mem_be, ld ? 4'hF : model_be(f3, lo));
        end
        if (st) begin
          checks++;
          if (mem_wdata !== model_wdata(f3, sd)) begin
            failures++;
            $display("FAIL %s mem_wdata got=%h exp=%h", name, mem_wdata, model_wdata(f3, sd));
          end
        end
        mem_gnt    = (i == gnt_dly);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        @(negedge clk);
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      checks++;
      if (mem_req !== 1'b0) begin
        failures++;
        $display("FAIL %s mem_req_after_gnt got=%b exp=0", name, mem_req);
      end
      if (ld) begin
        for (int i = 0; i <= rv_dly; i++) begin
          checks++;
          if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s early_wb_valid got=%b exp=0", name, wb_valid);
          end
          mem_rvalid = (i == rv_dly);
          mem_rdata  = (i == rv_dly) ? rd : $urandom;
          mem_gnt    = 1'($urandom);
          @(negedge clk);
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
      end
    end else if (trap) begin
      checks++;
      if (mem_req !== 1'b0) begin
        failures++;
        $display("FAIL %s trap_mem_req got=%b exp=0", name, mem_req);
      end
    end

    exp_we   = !trap && !st;
    exp_data = ld ? model_load(f3, lo, rd) : addr;
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== exp_we || wb_dstreg !== dst || misaligned !== trap) begin
      failures++;
      $display("FAIL %s wb valid/we/dst/mis got=%b/%b/%0d/%b exp=1/%b/%0d/%b",
               name, wb_valid, wb_we, wb_dstreg, misaligned, exp_we, dst, trap);
    end
    if (exp_we) begin
      checks++;
      if (wb_data !== exp_data) begin
        failures++;
        $display("FAIL %s wb_data got=%h exp=%h", name, wb_data, exp_data);
      end
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || misaligned !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after_resp valid/mis/ready got=%b/%b/%b exp=0/0/1",
               name, wb_valid, misaligned, in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mem_req, mem_we, mem_be, wb_valid, wb_we, misaligned} !== 10'b1_0_0_0000_0_0_0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b%b%b%b%b%b%b exp=1000000000",
               in_ready, mem_req, mem_we, mem_be, wb_valid, wb_we, misaligned);
    end
    checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || wb_data !== 32'd0 || wb_dstreg !== 5'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%0d exp=0/0/0/0", mem_addr, mem_wdata, wb_data, wb_dstreg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store();
    do_op("sw_0x100", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 32'd0, 0, 0);
    do_op("sb_0x103", 1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd0, 32'd0, 1, 0);
    do_op("sh_0x102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 5'd0, 32'd0, 2, 0);
  endtask

  task automatic test_load();
    do_op("lb_0x102", 1'b1, 1'b0, 3'b000, 32'h102, 32'd0, 5'd9, 32'h1280_FF00, 3, 0);
    do_op("lhu_0x202", 1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 5'd10, 32'h8001_5A5A, 0, 2);
    do_op("lh_0x202", 1'b1, 1'b0, 3'b001, 32'h202, 32'd0, 5'd11, 32'h8001_5A5A, 1, 1);
    do_op("lw_0x300", 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd12, 32'hCAFE_F00D, 0, 0);
    do_op("ld_and_st", 1'b1, 1'b1, 3'b100, 32'h401, 32'hFFFF_FFFF, 5'd13, 32'h0000_F700, 0, 0);
    do_op("lw_unsup_011", 1'b1, 1'b0, 3'b011, 32'h500, 32'd0, 5'd14, 32'h8765_4321, 0, 0);
  endtask

  task automatic test_nonmem();
    do_op("alu_pass", 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'd0, 5'd5, 32'd0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    for (int k = 0; k < 4; k++) vals[k] = $urandom;
    in_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
    alu_result = vals[0]; dstreg_num = 5'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== vals[k] || wb_dstreg !== 5'(k + 1) || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_op%0d valid/data/dst/ready got=%b/%h/%0d/%b exp=1/%h/%0d/0",
                 k, wb_valid, wb_data, wb_dstreg, in_ready, vals[k], k + 1);
      end
      if (k < 3) begin
        alu_result = vals[k+1]; dstreg_num = 5'(k + 2);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_gap%0d valid/ready got=%b/%b exp=0/1", k, wb_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
    funct3 = 3'b010; alu_result = 32'h0000_0300; dstreg_num = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    mem_gnt  = 1'b1;
    @(negedge clk);
    mem_gnt  = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1 || mem_addr !== 32'd0 ||
        wb_dstreg !== 5'd0 || mem_be !== 4'd0) begin
      failures++;
      $display("FAIL rst_mid req/wbv/ready/addr/dst/be got=%b/%b/%b/%h/%0d/%b exp=0/0/1/0/0/0",
               mem_req, wb_valid, in_ready, mem_addr, wb_dstreg, mem_be);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wb_valid !== 1'b0 || wb_data !== 32'd0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL late_rvalid%0d valid/data/ready got=%b/%h/%b exp=0/0/1",
                 i, wb_valid, wb_data, in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misalign();
    do_op("lw_0x101", 1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 5'd3, 32'h4433_2211, 0, 0);
    do_op("sh_0x201", 1'b0, 1'b1, 3'b001, 32'h201, 32'h0000_BEEF, 5'd0, 32'd0, 0, 0);
    do_op("lh_0x203", 1'b1, 1'b0, 3'b001, 32'h203, 32'd0, 5'd4, 32'hF123_8456, 1, 0);
  endtask

  task automatic test_random();
    logic [2:0] st_codes [6];
    st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 3);
      f3 = (kind == 2) ? st_codes[$urandom_range(0, 5)] : 3'($urandom);
      do_op($sformatf("rand%0d", n), kind == 1 || kind == 3, kind >= 2, f3,
            $urandom, $urandom, 5'($urandom), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; alu_result = 32'd0; store_data = 32'd0; dstreg_num = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    test_reset();
    test_store();
    test_load();
    test_nonmem();
    test_back_to_back();
    test_reset_mid_op();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective address, plus decoder flags (is_load, is_store, dstreg_num) and store data from the register file. Drives a req/gnt/rvalid data-memory handshake, aligns and sign/zero-extends load data, and presents one writeback beat per accepted op. Non-memory ops pass the ALU result through to writeback.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed at 32; byte lanes = 4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream op valid
in_ready  out  1  LSU can accept (state IDLE)
is_load  in  1  op is a load
is_store  in  1  op is a store
funct3  in  3  access size/sign (RV32I encoding)
alu_result  in  32  effective address, or result for non-memory ops
store_data  in  32  rs2 value
dstreg_num  in  5  destination register
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load word
wb_valid  out  1  one-cycle writeback/completion pulse
wb_we  out  1  write register file
wb_dstreg  out  5  destination register
wb_data  out  32  writeback value
misaligned  out  1  misalignment pulse (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; mem_req, mem_we, mem_be, wb_valid, wb_we, misaligned = 0; mem_addr, mem_wdata, wb_data = 0; wb_dstreg = 0.
- Accept on in_valid & in_ready; all inputs registered. in_ready = (state==IDLE).
- States: IDLE, REQ, WAIT, RESP.
- Non-memory op: IDLE->RESP. Next cycle: wb_valid=1, wb_we=1, wb_data=alu_result. Latency 1.
- Store: IDLE->REQ. mem_req=1, mem_we=1 until mem_gnt. On gnt, go to RESP. Next cycle: wb_valid=1, wb_we=0. Minimum latency 2.
- Load: IDLE->REQ. mem_req=1, mem_we=0 until gnt, then WAIT. mem_rvalid is honoured only in WAIT; the earliest is the cycle after gnt. On rvalid, register the extended data and go to RESP; wb_valid=1, wb_we=1. Minimum latency 3.
- RESP->IDLE unconditionally. Back-to-back accept is possible on the cycle after RESP.
- mem_addr, mem_we, mem_be and mem_wdata are stable for the whole time mem_req is high.
- Byte lanes, lane = addr[1:0]:
  - SB: be = 1<<lane; wdata = byte replicated x4.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = half replicated x2.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111.
- Load extension:
  - LB (000) / LBU (100): byte at lane, sign- / zero-extended.
  - LH (001) / LHU (101): half at addr[1], sign- / zero-extended.
  - LW (010): full word.
- Unsupported funct3 (011, 110, 111) is treated as word access.
- is_load & is_store both high: load takes priority.
- rvalid in IDLE/REQ/RESP and gnt outside REQ are ignored.
- Reset mid-operation aborts to IDLE. A late rvalid after reset is ignored.

Optional Feature:
LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. It never asserts mem_req; it goes IDLE->RESP and the next cycle gives wb_valid=1, wb_we=0, misaligned=1 (one cycle).
- Undefined: misaligned is tied 0. The access proceeds with the low address bits ignored per the lane rules above.

Decomposition:
- define.vh adds: LSU state encodings; funct3 size codes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
- One combinational sub-module, lsu_align. It produces mem_be and mem_wdata from store data, and extended load data from rdata, using funct3 and addr[1:0].

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt same cycle as req -> mem_be=1111, mem_addr=0x100, wb_valid at T+2 with wb_we=0.
- SB addr=0x103, data=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x102, rdata=0x1280FF00, gnt delayed 3 cycles -> mem_req held 4 cycles; wb_data=0xFFFFFF80, wb_we=1, dstreg echoed.
- LHU addr=0x202, rdata=0x8001xxxx -> wb_data=0x00008001; LH on the same data -> 0xFFFF8001.
- Non-memory op, alu_result=0x12345678, dstreg=5 -> wb_valid at T+1, wb_data=0x12345678; back-to-back ops accepted every 2 cycles.
- rst_n low while in WAIT, then rvalid -> outputs zero, no wb_valid. With LSU_MISALIGN_TRAP_EN, LW addr=0x101 -> no mem_req, misaligned=1 at T+1.
